// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath: 2-5 cycles per instruction.
// No backpressure; only PCEn (and the live Op/Funct decode in DECODE/EXECUTE) depends on inputs.
module multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b011000: funct_alu = ALU_MUL;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Reset wins over any pending transition, so a write state never survives the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = funct_ok ? ALUWB : FETCH;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: Illegal = 1'b0;
          default:                                       Illegal = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        Illegal    = !funct_ok;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn = PCWrite | (Branch & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction output schedule.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       zero;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .zero(zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCEn(PCEn), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  // Packed view of every Moore output, in a fixed field order.
  logic [16:0] got_w;
  assign got_w = {IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] w(input logic iord, input logic mw, input logic irw,
                                    input logic pcw, input logic br, input logic rd,
                                    input logic m2r, input logic rw, input logic sa,
                                    input logic [1:0] sb, input logic [1:0] pcs,
                                    input logic [2:0] alu, input logic ill);
    return {iord, mw, irw, pcw, br, rd, m2r, rw, sa, sb, pcs, alu, ill};
  endfunction

  // Funct table: {legal, ALU code}
  function automatic logic [3:0] funct_map(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_100;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_110;
      6'b011000: return 4'b1_101;
      default:   return 4'b0_010;
    endcase
  endfunction

  function automatic bit op_legal(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  logic [16:0] fetch_w;
  assign fetch_w = w(0,0,1,1,0,0,0,0,0,2'b01,2'b00,3'b010,0);

  // Expected output per cycle of one instruction, from FETCH up to the cycle before the next FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] f,
                       output logic [16:0] seq [0:4], output int n);
    logic [16:0] dec_w;
    logic [3:0]  fm;
    dec_w = w(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    fm    = funct_map(f);
    for (int i = 0; i < 5; i++) seq[i] = '0;
    seq[0] = fetch_w;
    seq[1] = dec_w;
    n = 2;
    case (op)
      6'b100011: begin
        seq[2] = w(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
        seq[3] = w(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
        seq[4] = w(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0);
        n = 5;
      end
      6'b101011: begin
        seq[2] = w(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
        seq[3] = w(1,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
        n = 4;
      end
      6'b000000: begin
        seq[2] = w(0,0,0,0,0,0,0,0,1,2'b00,2'b00,fm[2:0],!fm[3]);
        if (fm[3]) begin
          seq[3] = w(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0);
          n = 4;
        end else begin
          n = 3;
        end
      end
      6'b000100: begin
        seq[2] = w(0,0,0,0,1,0,0,0,1,2'b00,2'b01,3'b100,0);
        n = 3;
      end
      6'b001000: begin
        seq[2] = w(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
        seq[3] = w(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0);
        n = 4;
      end
      6'b000010: begin
        seq[2] = w(0,0,0,1,0,0,0,0,0,2'b00,2'b10,3'b010,0);
        n = 3;
      end
      default: begin
        seq[1] = w(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
        n = 2;
      end
    endcase
  endtask

  logic [5:0] legal_ops   [0:5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] legal_functs[0:5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

  initial begin
    logic [5:0]  op, f;
    logic [16:0] seq [0:4];
    logic [16:0] ew;
    int          n, rst_step, hold_until, zmode;

    reset_n = 1'b0;
    Op      = 6'b000000;
    Funct   = 6'b000000;
    zero    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      Op    = 6'($urandom);
      Funct = 6'($urandom);
      zero  = 1'($urandom);
      #2;
      chk("reset_out", 32'(got_w), 32'(fetch_w));
      chk("reset_pcen", 32'(PCEn), 32'd1);
    end

    for (int i = 0; i < 300; i++) begin
      op       = legal_ops[$urandom_range(0, 5)];
      f        = legal_functs[$urandom_range(0, 5)];
      zmode    = -1;
      rst_step = -1;
      if ($urandom_range(0, 5) == 0) begin
        op = 6'($urandom);
        if (op_legal(op)) op = 6'b111111;
      end
      if ($urandom_range(0, 4) == 0) begin
        f = 6'($urandom);
        if (funct_map(f) >= 4'b1000) f = 6'b000000;
      end
      case (i)
        0: op = 6'b100011;
        1: begin op = 6'b000000; f = 6'b100010; end
        2: begin op = 6'b000000; f = 6'b101010; end
        3: begin op = 6'b000000; f = 6'b011000; end
        4: begin op = 6'b000000; f = 6'b000000; end
        5: op = 6'b111111;
        6: begin op = 6'b000100; zmode = 1; end
        7: begin op = 6'b000100; zmode = 0; end
        8: begin op = 6'b101011; rst_step = 3; end
        9: begin op = 6'b100011; rst_step = 4; end
        default: ;
      endcase
      build(op, f, seq, n);
      if (i >= 10 && n > 2 && $urandom_range(0, 7) == 0) rst_step = $urandom_range(1, n - 1);
      hold_until = (op == 6'b100011 || op == 6'b101011 || op == 6'b000000) ? 2 : 1;

      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (k >= 1 && k <= hold_until) begin
          Op    = op;
          Funct = f;
        end else begin
          Op    = 6'($urandom);
          Funct = 6'($urandom);
        end
        zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        if (k == rst_step) begin
          reset_n = 1'b0;
          @(negedge clk);
          Op    = 6'($urandom);
          Funct = 6'($urandom);
          zero  = 1'($urandom);
          #2;
          chk("midrst_out", 32'(got_w), 32'(fetch_w));
          chk("midrst_pcen", 32'(PCEn), 32'd1);
          break;
        end
        reset_n = 1'b1;
        #2;
        ew = seq[k];
        chk("out", 32'(got_w), 32'(ew));
        chk("pcen", 32'(PCEn), 32'(ew[13] | (ew[12] & zero)));
      end
    end

    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("final_fetch", 32'(got_w), 32'(fetch_w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: Op  input  6  instruction opcode (IR[31:26]).
REQ-004 SHALL have port: Funct  input  6  R-type function field (IR[5:0]).
REQ-005 SHALL have port: zero  input  1  ALU zero flag from the datapath ALU.
REQ-006 SHALL have outputs, all 1 bit unless noted: IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ALUControl[2:0], Illegal.
REQ-007 SHALL have ALUControl encoding: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT; 011/111 never driven.

Function
REQ-008 SHALL be a Moore FSM, states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-009 SHALL decode Op: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
REQ-010 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1; next DECODE.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target); next by Op: lw/sw->MEMADR, R-type->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP.
REQ-012 DECODE with unlisted Op SHALL pulse Illegal=1 for that cycle and go to FETCH.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next MEMRD (lw) or MEMWR (sw).
REQ-014 MEMRD: IorD=1; next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-015 MEMWR: IorD=1, MemWrite=1; next FETCH.
REQ-016 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 100000->010, 100010->100, 100100->000, 100101->001, 101010->110, 011000->101; next ALUWB.
REQ-017 EXECUTE with unlisted Funct SHALL drive ALUControl=010, pulse Illegal, and go to FETCH (no ALUWB, no RegWrite).
REQ-018 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=100, Branch=1, PCSrc=01; next FETCH.
REQ-020 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-021 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-022 PCEn SHALL be combinational: PCWrite | (Branch & zero); only output that depends on an input.
REQ-023 Any output not listed for a state SHALL be 0 (ALUControl 010, ALUSrcB 00, PCSrc 00).
REQ-024 Op/Funct SHALL be sampled only in DECODE/EXECUTE/MEMADR decisions; changes elsewhere have no effect.
REQ-025 Latency (cycles, FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-026 Unreachable state encodings SHALL transition to FETCH on next edge.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force state FETCH, overriding any transition, including mid-instruction.
REQ-028 During and after reset, outputs SHALL be FETCH values (IRWrite=1, PCWrite=1, PCEn=1, ALUControl=010, all writes to memory/regfile 0); Illegal=0.
REQ-029 Asserting reset in MEMWR/ALUWB/MEMWB SHALL suppress that state's MemWrite/RegWrite from the edge onward; no partial write after the edge.

Verification
REQ-030 lw (Op=100011): FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; back in FETCH cycle 6.
REQ-031 R-type Funct=100010 then 101010: ALUControl=100 then 110 in EXECUTE; RegDst=1, RegWrite=1 in ALUWB.
REQ-032 beq zero=1 -> PCEn=1 in BRANCH; zero=0 -> PCEn=0; ALUControl=100, PCSrc=01 both cases.
REQ-033 Op=111111 -> Illegal=1 in DECODE only, FETCH next, no RegWrite/MemWrite seen.
REQ-034 Funct=011000 -> ALUControl=101; Funct=000000 -> Illegal pulse, no ALUWB.
REQ-035 reset_n=0 during MEMWR of sw -> MemWrite=0 after edge, state FETCH, outputs per REQ-028.
